// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - serial pattern detector with loadable pattern, match counter and 7-seg status
// Optional display: define SEQDET_DISPLAY_EN to build the 7-segment decoder and dp pulse stretcher.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 4,
    parameter int DP_HOLD = 4,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               configured,
    output logic [7:0]         seg_out
);

    typedef enum logic {UNCFG, RUN} state_t;

    state_t             state;
    logic [MAX_LEN-1:0] pattern;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   fill;
    logic               overlap;

    logic               accept;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_clamped;
    logic               hit;

    always_comb begin
        accept      = (state == RUN) && en && din_valid && !cfg_load;
        hist_next   = {hist[MAX_LEN-2:0], din};
        fill_next   = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
        len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
        mask        = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        // Compare on the post-shift history so the match registers on the same edge as the bit
        hit = accept && (fill_next >= len) && ((hist_next & mask) == (pattern & mask));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= UNCFG;
            pattern     <= '0;
            hist        <= '0;
            len         <= '0;
            fill        <= '0;
            overlap     <= 1'b0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            match <= 1'b0;
            if (cfg_load) begin
                pattern     <= cfg_pattern;
                len         <= len_clamped;
                overlap     <= cfg_overlap;
                hist        <= '0;
                fill        <= '0;
                match_count <= '0;
                state       <= (cfg_len == '0) ? UNCFG : RUN;
            end else begin
                if (accept) begin
                    hist <= hist_next;
                    fill <= (hit && !overlap) ? '0 : fill_next;
                end
                match <= hit;
                if (count_clr) begin
                    match_count <= '0;
                end else if (hit) begin
                    match_count <= match_count + 1'b1;
                end
            end
        end
    end

    assign configured = (state == RUN);

`ifdef SEQDET_DISPLAY_EN
    localparam int DP_W = $clog2(DP_HOLD + 1);

    logic [6:0]      digit;
    logic [DP_W-1:0] dp_cnt;

    function automatic logic [6:0] font(input logic [3:0] v);
        case (v)
            4'h0: font = 7'h3F;
            4'h1: font = 7'h06;
            4'h2: font = 7'h5B;
            4'h3: font = 7'h4F;
            4'h4: font = 7'h66;
            4'h5: font = 7'h6D;
            4'h6: font = 7'h7D;
            4'h7: font = 7'h07;
            4'h8: font = 7'h7F;
            4'h9: font = 7'h6F;
            4'hA: font = 7'h77;
            4'hB: font = 7'h7C;
            4'hC: font = 7'h39;
            4'hD: font = 7'h5E;
            4'hE: font = 7'h79;
            default: font = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit  <= 7'h40;
            dp_cnt <= '0;
        end else begin
            digit <= (state == RUN) ? font(match_count[3:0]) : 7'h40;
            if (match) begin
                dp_cnt <= DP_W'(DP_HOLD);
            end else if (dp_cnt != '0) begin
                dp_cnt <= dp_cnt - 1'b1;
            end
        end
    end

    assign seg_out = {(dp_cnt != '0), digit};
`else
    assign seg_out = 8'h00;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - self-checking bench for seq_detector_param (vector tables, corner sequences, random vs model)
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 4;
    localparam int DP_HOLD = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               din = 1'b0;
    logic               din_valid = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               count_clr = 1'b0;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               configured;
    logic [7:0]         seg_out;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .DP_HOLD(DP_HOLD)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .count_clr(count_clr), .match(match),
        .match_count(match_count), .configured(configured), .seg_out(seg_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         load;
        logic [7:0] pat;
        logic [3:0] len;
        bit         ov;
        bit         en;
        bit         dv;
        bit         din;
        bit         clr;
    } in_t;

    typedef struct {
        in_t i;
        bit  m;
        int  c;
    } vec_t;

    logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int tests = 0;
    int fails = 0;

    // Reference model: accepted-bit history as a queue, matches found by comparing its tail
    bit         m_cfg;
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ov;
    bit         bits[$];
    int         m_count;
    bit         m_match;
    int         edge_n;
    int         last_dp;
    vec_t       vecs[$];

    function automatic logic [7:0] disp(input logic [7:0] v);
`ifdef SEQDET_DISPLAY_EN
        return v;
`else
        return 8'h00;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t x = '{default: 0};
        x.en = 1;
        return x;
    endfunction

    function automatic in_t bit_in(input bit d);
        in_t x = idle();
        x.dv  = 1;
        x.din = d;
        return x;
    endfunction

    function automatic in_t load_in(input logic [7:0] p, input logic [3:0] l, input bit ov);
        in_t x = idle();
        x.load = 1;
        x.pat  = p;
        x.len  = l;
        x.ov   = ov;
        return x;
    endfunction

    task automatic model_reset();
        m_cfg   = 0;
        m_pat   = '0;
        m_len   = 0;
        m_ov    = 0;
        bits.delete();
        m_count = 0;
        m_match = 0;
        last_dp = -1000;
    endtask

    task automatic cycle(input in_t x);
        bit         pre_cfg, pre_match, hit, ok;
        int         pre_count;
        logic [7:0] exp_seg;
        cfg_load    = x.load;
        cfg_pattern = x.pat;
        cfg_len     = x.len;
        cfg_overlap = x.ov;
        en          = x.en;
        din_valid   = x.dv;
        din         = x.din;
        count_clr   = x.clr;

        pre_cfg   = m_cfg;
        pre_count = m_count;
        pre_match = m_match;
        hit       = 0;
        if (x.load) begin
            m_pat   = x.pat;
            m_len   = (x.len > 4'(MAX_LEN)) ? MAX_LEN : int'(x.len);
            m_ov    = x.ov;
            m_cfg   = (x.len != 0);
            m_count = 0;
            bits.delete();
        end else begin
            if (m_cfg && x.en && x.dv) begin
                bits.push_back(x.din);
                if (bits.size() > MAX_LEN) void'(bits.pop_front());
                if (bits.size() >= m_len) begin
                    ok = 1;
                    for (int k = 0; k < m_len; k++)
                        if (bits[bits.size() - 1 - k] != m_pat[k]) ok = 0;
                    hit = ok;
                    if (hit && !m_ov) bits.delete();
                end
            end
            if (x.clr) m_count = 0;
            else if (hit) m_count = (m_count + 1) % (1 << CNT_W);
        end
        m_match = hit;
        edge_n++;
        if (pre_match) last_dp = edge_n;
        exp_seg[6:0] = pre_cfg ? font_tab[pre_count % 16] : 7'h40;
        exp_seg[7]   = (edge_n - last_dp) < DP_HOLD;

        @(posedge clk);
        #1;
        check("match", 32'(match), 32'(m_match));
        check("match_count", 32'(match_count), 32'(m_count));
        check("configured", 32'(configured), 32'(m_cfg));
        check("seg_out", 32'(seg_out), 32'(disp(exp_seg)));
    endtask

    task automatic run_vecs();
        foreach (vecs[n]) begin
            cycle(vecs[n].i);
            check("vec_match", 32'(match), 32'(vecs[n].m));
            check("vec_count", 32'(match_count), 32'(vecs[n].c));
        end
        vecs.delete();
    endtask

    task automatic idles(input int n);
        for (int k = 0; k < n; k++) cycle(idle());
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_match"}, 32'(match), 32'd0);
        check({tag, "_count"}, 32'(match_count), 32'd0);
        check({tag, "_configured"}, 32'(configured), 32'd0);
        check({tag, "_seg"}, 32'(seg_out), 32'(disp(8'h40)));
    endtask

    initial begin
        in_t x;
        model_reset();
        edge_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 0;

        // UNCFG ignores data
        for (int k = 0; k < 4; k++) cycle(bit_in(1));

        // Pattern 1011 with overlap; an en-low cycle is frozen in the middle
        vecs.push_back('{load_in(8'b1011, 4, 1), 0, 0});
        vecs.push_back('{bit_in(1), 0, 0});
        vecs.push_back('{bit_in(0), 0, 0});
        vecs.push_back('{bit_in(1), 0, 0});
        vecs.push_back('{bit_in(1), 1, 1});
        vecs.push_back('{bit_in(0), 0, 1});
        x = bit_in(1); x.en = 0;
        vecs.push_back('{x, 0, 1});
        vecs.push_back('{bit_in(1), 0, 1});
        vecs.push_back('{bit_in(1), 1, 2});
        run_vecs();
        cycle(idle());
        check("dp_hold_seg", 32'(seg_out), 32'(disp(8'hDB)));
        idles(DP_HOLD);
        check("dp_done_seg", 32'(seg_out), 32'(disp(8'h5B)));

        // Same pattern without overlap
        vecs.push_back('{load_in(8'b1011, 4, 0), 0, 0});
        vecs.push_back('{bit_in(1), 0, 0});
        vecs.push_back('{bit_in(0), 0, 0});
        vecs.push_back('{bit_in(1), 0, 0});
        vecs.push_back('{bit_in(1), 1, 1});
        vecs.push_back('{bit_in(0), 0, 1});
        vecs.push_back('{bit_in(1), 0, 1});
        vecs.push_back('{bit_in(1), 0, 1});
        run_vecs();
        idles(DP_HOLD + 1);
        check("nonovl_seg", 32'(seg_out), 32'(disp(8'h06)));
        // count_clr coinciding with a match leaves the count at zero
        vecs.push_back('{bit_in(0), 0, 1});
        vecs.push_back('{bit_in(1), 0, 1});
        x = bit_in(1); x.clr = 1;
        vecs.push_back('{x, 1, 0});
        run_vecs();

        // Load on the same edge as a valid bit: bit dropped, count cleared
        cycle(load_in(8'b11, 2, 1));
        cycle(bit_in(1));
        x = load_in(8'b11, 2, 1); x.dv = 1; x.din = 1;
        cycle(x);
        check("load_vs_bit_count", 32'(match_count), 32'd0);
        cycle(bit_in(1));
        check("load_vs_bit_nomatch", 32'(match), 32'd0);
        // Consecutive matches then wrap after 16
        for (int k = 0; k < 16; k++) cycle(bit_in(1));
        check("wrap_count", 32'(match_count), 32'd0);
        idles(DP_HOLD + 1);
        check("wrap_seg", 32'(seg_out), 32'(disp(8'h3F)));

        // Zero length unconfigures
        cycle(load_in(8'h5A, 0, 1));
        check("len0_configured", 32'(configured), 32'd0);
        cycle(bit_in(1));
        check("len0_seg", 32'(seg_out), 32'(disp(8'h40)));
        for (int k = 0; k < 4; k++) cycle(bit_in(k[0]));

        // Length above MAX_LEN clamps to MAX_LEN
        cycle(load_in(8'b10110010, 12, 1));
        for (int k = 7; k >= 0; k--) begin
            x = bit_in(k == 7 || k == 5 || k == 4 || k == 1);
            cycle(x);
            check("clamp_match", 32'(match), 32'(k == 0));
        end

        // Asynchronous reset mid-stream
        cycle(load_in(8'b01, 2, 1));
        cycle(bit_in(0));
        cycle(bit_in(1));
        #2 rst = 1;
        #1;
        model_reset();
        check_reset_values("async_reset");
        @(posedge clk);
        #1 rst = 0;
        for (int k = 0; k < 3; k++) cycle(bit_in(1));

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            x      = idle();
            x.en   = ($urandom_range(0, 9) != 0);
            x.dv   = ($urandom_range(0, 4) != 0);
            x.din  = 1'($urandom);
            x.clr  = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 60) == 0) begin
                x.load = 1;
                x.pat  = 8'($urandom);
                x.len  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(1, 4));
                x.ov   = 1'($urandom);
            end
            cycle(x);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector with a runtime-loadable pattern, selectable overlap mode, a match counter and a registered 7-segment status display. It is the next-generation replacement for the fixed-pattern detector in the Tiny Tapeout wrapper. Serial bits arrive on `din` qualified by `din_valid`, and `seg_out` drives the board display directly.

## Interface
Parameters:
- `MAX_LEN`, default 8: maximum pattern length in bits (2..15).
- `CNT_W`, default 4: match counter width (≥4).
- `DP_HOLD`, default 4: number of cycles the decimal point stays lit after a match (≥1).
- `LEN_W`, derived as `$clog2(MAX_LEN+1)`: width of `cfg_len`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: global enable; when low, `din_valid` is ignored (cfg and clear still act).
- `din` in 1: serial data bit.
- `din_valid` in 1: `din` is accepted on this edge.
- `cfg_load` in 1: one-cycle strobe that latches the configuration.
- `cfg_pattern` in MAX_LEN: pattern; `cfg_pattern[L-1]` is the first bit received, `[0]` the last.
- `cfg_len` in LEN_W: pattern length L.
- `cfg_overlap` in 1: 1 = overlapping matches allowed, 0 = history cleared after each match.
- `count_clr` in 1: synchronous clear of `match_count`.
- `match` out 1: one-cycle pulse per detected pattern.
- `match_count` out CNT_W: number of matches, wraps modulo 2^CNT_W.
- `configured` out 1: high when a valid pattern is loaded.
- `seg_out` out 8: `{dp,g,f,e,d,c,b,a}`, active-high.

## Operation
- FSM states:
  - UNCFG (reset state): `din_valid` is ignored and `match` stays 0.
  - RUN: detection active.
- `cfg_load` in any state:
  - latches pattern, length and overlap flag;
  - clears history, fill counter and `match_count`.
  - `cfg_len`=0 → UNCFG.
  - `cfg_len`>MAX_LEN → clamped to MAX_LEN, then RUN.
  - otherwise → RUN.
- History register `hist[MAX_LEN-1:0]`: on each accepted bit (RUN & `en` & `din_valid` & !`cfg_load`), `hist <= {hist[MAX_LEN-2:0], din}`.
- Fill counter: increments per accepted bit, saturates at MAX_LEN.
- Match condition: evaluated combinationally on the post-shift value.
  - requires fill ≥ L and `hist[L-1:0] == pattern[L-1:0]`;
  - registered into `match`.
- On a match:
  - `match_count` increments (wraps);
  - if `cfg_overlap`=0, fill is cleared to 0 on the same edge, so earlier bits cannot contribute to the next match.
- Simultaneous events:
  - `cfg_load` with `din_valid`: load wins and the bit is discarded.
  - `count_clr` with a match: the count becomes 0.
  - `cfg_load` with `count_clr`: the count becomes 0.
- Display (registered):
  - UNCFG → 0x40 ("-").
  - RUN → hex font of `match_count[3:0]`: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - `dp` (bit 7) is a pulse stretcher: it loads DP_HOLD when `match` is high, decrements to 0, and `dp`=1 while nonzero. A new match reloads it.
- Reset values:
  - `match`=0, `match_count`=0, `configured`=0, `seg_out`=0x40;
  - pattern, length, history, fill and dp counter all 0;
  - state UNCFG.
- Reset asserted mid-stream discards all state immediately, asynchronously.

## Timing
- Bit accepted at edge N → `match` high for the cycle after edge N (latency 1). `match_count` updates at the same edge N.
- `seg_out` digit and `dp` reflect a match at edge N+1 (latency 2 from bit acceptance).
- `dp` stays high for exactly DP_HOLD cycles after a single isolated match.
- `cfg_load` at edge N → `configured` and the new `seg_out` state are valid after edges N and N+1 respectively. The first usable bit is accepted at edge N+1.
- Back-to-back `din_valid` every cycle is supported with no stalls. In overlap mode `match` may be high on consecutive cycles (e.g. pattern 11, stream 111).
- `en` low freezes history, fill and the FSM. The display and dp counter keep running.

## Configuration
- Macro `SEQDET_DISPLAY_EN`.
- Defined: the 7-segment decoder and dp pulse stretcher are compiled in as described above.
- Undefined: decoder and stretcher are omitted and `seg_out` is tied to 8'h00, including during and after reset. `match`, `match_count` and `configured` behave identically.

## Test plan
- Reset with `rst`=1 mid-stream → `seg_out`=0x40, `match`=0, `match_count`=0, `configured`=0; `din_valid` pulses in UNCFG give no match.
- Load pattern 4'b1011, L=4, overlap=1; stream 1,0,1,1,0,1,1 → `match` after bits 4 and 7, count=2, `seg_out`=0xDB during dp hold, then 0x5B after DP_HOLD cycles.
- Same pattern with overlap=0; stream 1,0,1,1,0,1,1 → single match after bit 4, count=1, `seg_out` settles at 0x06.
- `cfg_load` on the same edge as `din_valid`=1 → bit discarded and count reset to 0. Then feed 16 matches with CNT_W=4 → count wraps to 0 and `seg_out` shows 0x3F.
- `cfg_len`=0 → `configured`=0 and `seg_out`=0x40. `cfg_len`=12 with MAX_LEN=8 → L clamped to 8; an 8-bit pattern matches after the 8th bit.
- Build without `SEQDET_DISPLAY_EN`, rerun the second scenario → identical `match`/`match_count`, `seg_out`=0x00 throughout.
